// File: rtl/cva5_types.sv
// Shared types and constants for the unsigned square-root core.
// Holds the FSM state enum and the iteration-count helpers.
package cva5_types;

    localparam int SQRT_DATA_WIDTH = 32;
    localparam int SQRT_ITERATIONS = SQRT_DATA_WIDTH / 2;

    typedef enum logic {
        SQRT_IDLE = 1'b0,
        SQRT_BUSY = 1'b1
    } sqrt_state_t;

    // One result bit is produced per iteration.
    function automatic int sqrt_iterations(input int data_width);
        return data_width / 2;
    endfunction

endpackage

// File: rtl/unsigned_sqrt_interface.sv
// Request/response bundle for the square-root core.
// sqrt modport: start/radicand in, done/result/remainder out.
interface unsigned_sqrt_interface #(
    parameter int DATA_WIDTH = 32
);

    logic                  start;
    logic [DATA_WIDTH-1:0] radicand;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] remainder;

    modport sqrt (
        input  start,
        input  radicand,
        output done,
        output result,
        output remainder
    );

    modport requester (
        output start,
        output radicand,
        input  done,
        input  result,
        input  remainder
    );

endinterface

// File: rtl/sqrt_step.sv
// One combinational restoring square-root step.
// Ports: rem/root/bits in, rem_next/root_next out.
module sqrt_step
    import cva5_types::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH/2+1:0] rem,
    input  logic [DATA_WIDTH/2-1:0] root,
    input  logic [1:0]              bits,
    output logic [DATA_WIDTH/2+1:0] rem_next,
    output logic [DATA_WIDTH/2-1:0] root_next
);

    localparam int HW = DATA_WIDTH / 2;

    logic [HW+1:0] shifted;
    logic [HW+1:0] trial;
    logic [HW+2:0] diff;
    logic          fits;

    always_comb begin
        shifted   = (rem << 2) | {{HW{1'b0}}, bits};
        trial     = {root, 2'b01};
        // Extra top bit acts as the borrow of the trial subtraction.
        diff      = {1'b0, shifted} - {1'b0, trial};
        fits      = ~diff[HW+2];
        rem_next  = fits ? diff[HW+1:0] : shifted;
        root_next = (root << 1) | {{(HW-1){1'b0}}, fits};
    end

endmodule

// File: rtl/unsigned_sqrt_core.sv
// Iterative unsigned integer square root, one result bit per cycle.
// Ports: clk, rst (async active-low), sqrt (interface, sqrt modport).
module unsigned_sqrt_core
    import cva5_types::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input logic                  clk,
    input logic                  rst,
    unsigned_sqrt_interface.sqrt sqrt
);

    localparam int HW    = DATA_WIDTH / 2;
    localparam int ITERS = sqrt_iterations(DATA_WIDTH);
    localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

    sqrt_state_t           state;
    logic [DATA_WIDTH-1:0] rad_q;
    logic [HW+1:0]         rem_q;
    logic [HW+1:0]         rem_next;
    logic [HW-1:0]         root_q;
    logic [HW-1:0]         root_next;
    logic [CW-1:0]         count_q;
    logic                  last_step;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [DATA_WIDTH-1:0] remainder_q;

    assign last_step = (count_q == CW'(ITERS - 1));

    sqrt_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .rem      (rem_q),
        .root     (root_q),
        .bits     (rad_q[DATA_WIDTH-1 -: 2]),
        .rem_next (rem_next),
        .root_next(root_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SQRT_IDLE;
            rad_q       <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                SQRT_IDLE: begin
                    if (sqrt.start) begin
                        rad_q   <= sqrt.radicand;
                        rem_q   <= '0;
                        root_q  <= '0;
                        count_q <= '0;
                        state   <= SQRT_BUSY;
                    end
                end
                SQRT_BUSY: begin
                    rem_q  <= rem_next;
                    root_q <= root_next;
                    rad_q  <= rad_q << 2;
                    if (last_step) begin
                        count_q     <= '0;
                        state       <= SQRT_IDLE;
                        done_q      <= 1'b1;
                        result_q    <= DATA_WIDTH'(root_next);
                        remainder_q <= DATA_WIDTH'(rem_next);
                    end else begin
                        count_q <= count_q + CW'(1);
                    end
                end
                default: state <= SQRT_IDLE;
            endcase
        end
    end

    assign sqrt.done      = done_q;
    assign sqrt.result    = result_q;
    assign sqrt.remainder = remainder_q;

endmodule
